// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C request arbiter.
package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Round-robin winner selection: scans the request vector starting at the
// pointer, wrapping around, and reports the first set line. Purely
// combinational; the caller registers the result.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IW-1:0]      win_idx
);

    logic found;
    int   pos;

    // First set request at or after the pointer, modulo NUM_REQ
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        pos        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[pos]) begin
                found           = 1'b1;
                win_onehot[pos] = 1'b1;
                win_idx         = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among NUM_REQ requesters. Requests are granted
// round-robin and driven through the master's sel/enable handshake; completion
// is taken from the master's ready flag. Optional watchdog is built when
// I2C_ARB_TIMEOUT_EN is defined; otherwise err_o is constant 0.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            write_i,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] addr_i,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [I2C_DATA_W-1:0]         rdata_o,
    output logic                          err_o,
    output logic                          m_sel_o,
    output logic                          m_enable_o,
    output logic                          m_write_o,
    output logic [I2C_ADDR_W-1:0]         m_addr_o,
    output logic [I2C_DATA_W-1:0]         m_wdata_o,
    input  logic [I2C_DATA_W-1:0]         m_rdata_i,
    input  logic                          m_ready_i
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e             state_reg, state_next;
    logic [IW-1:0]          ptr_reg;
    logic [IW-1:0]          idx_reg;
    logic [NUM_REQ-1:0]     gnt_reg;
    logic                   write_reg;
    logic [I2C_ADDR_W-1:0]  addr_reg;
    logic [I2C_DATA_W-1:0]  wdata_reg;
    logic [I2C_DATA_W-1:0]  rdata_reg;
    logic                   err_reg;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IW-1:0]          pick_idx;
    logic                   timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req        (req_i),
        .ptr        (ptr_reg),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] tmo_cnt_reg;

    // Watchdog: cleared while in SETUP (i.e. on entry to ACCESS), counts in ACCESS/WAIT
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ACCESS || state_reg == WAIT) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ACCESS || state_reg == WAIT) &&
                         (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the watchdog takes priority over a late ready
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (m_ready_i && (|req_i)) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (timeout_hit) state_next = DONE;
                     else if (!m_ready_i) state_next = WAIT;
            WAIT:    if (timeout_hit) state_next = DONE;
                     else if (m_ready_i) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction registers: latch winner in IDLE, capture result on entry to DONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg   <= '0;
            idx_reg   <= '0;
            gnt_reg   <= '0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (state_next == SETUP) begin
                        idx_reg   <= pick_idx;
                        gnt_reg   <= pick_onehot;
                        write_reg <= write_i[pick_idx];
                        addr_reg  <= addr_i[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                        wdata_reg <= wdata_i[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
                    end
                end
                ACCESS, WAIT: begin
                    if (state_next == DONE) begin
                        rdata_reg <= timeout_hit ? '0 : m_rdata_i;
                        err_reg   <= timeout_hit;
                    end
                end
                DONE: begin
                    gnt_reg <= '0;
                    err_reg <= 1'b0;
                    ptr_reg <= (idx_reg == IW'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state and latched payload only
    always_comb begin
        gnt_o      = gnt_reg;
        done_o     = (state_reg == DONE) ? gnt_reg : '0;
        err_o      = (state_reg == DONE) && err_reg;
        rdata_o    = rdata_reg;
        m_sel_o    = (state_reg == SETUP) || (state_reg == ACCESS);
        m_enable_o = (state_reg == ACCESS);
        m_write_o  = write_reg;
        m_addr_o   = addr_reg;
        m_wdata_o  = wdata_reg;
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter with a behavioural I2C master and a
// round-robin reference model. Timeout checks are compiled only when
// I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_req_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic [N-1:0]     req_i = '0;
    logic [N-1:0]     write_i = '0;
    logic [7*N-1:0]   addr_i = '0;
    logic [8*N-1:0]   wdata_i = '0;
    logic [N-1:0]     gnt_o, done_o;
    logic [7:0]       rdata_o;
    logic             err_o;
    logic             m_sel_o, m_enable_o, m_write_o;
    logic [6:0]       m_addr_o;
    logic [7:0]       m_wdata_o;
    logic [7:0]       m_rdata = '0;
    logic             m_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int ref_ptr = 0;

    logic       pw [N];
    logic [6:0] pa [N];
    logic [7:0] pd [N];

    int         busy_cnt = 0;
    int         txn_lat = 1;
    logic [7:0] txn_rdata = '0;
    bit         master_hold = 0;
    bit         master_flush = 0;

    always #5 clk = ~clk;

    i2c_req_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .write_i    (write_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .m_sel_o    (m_sel_o),
        .m_enable_o (m_enable_o),
        .m_write_o  (m_write_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_rdata_i  (m_rdata),
        .m_ready_i  (m_ready)
    );

    // Behavioural master: starts on sel&enable while idle, stays busy txn_lat cycles
    always @(posedge clk) begin
        if (rst_i) begin
            m_ready  <= 1'b1;
            busy_cnt <= 0;
            m_rdata  <= '0;
        end else if (master_flush) begin
            m_ready  <= 1'b1;
            busy_cnt <= 0;
        end else if (master_hold) begin
            m_ready <= 1'b0;
        end else if (m_ready && m_sel_o && m_enable_o) begin
            m_ready  <= 1'b0;
            busy_cnt <= txn_lat;
            m_rdata  <= txn_rdata;
        end else if (!m_ready) begin
            if (busy_cnt == 0) m_ready <= 1'b1;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration rule: first set request at or after the pointer, wrapping
    function automatic int ref_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++)
            if (g[k] === 1'b1) return k;
        return -1;
    endfunction

    task automatic pack_payload();
        for (int k = 0; k < N; k++) begin
            write_i[k]        = pw[k];
            addr_i[7*k +: 7]  = pa[k];
            wdata_i[8*k +: 8] = pd[k];
        end
    endtask

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            pw[k] = 1'($urandom_range(0, 1));
            pa[k] = 7'($urandom_range(0, 127));
            pd[k] = 8'($urandom_range(0, 255));
        end
        pack_payload();
    endtask

    // One full transaction from IDLE; called at a negedge with req_i already set
    task automatic run_one(input string tag, input int exp_lat, input bit drop_winner, output int won);
        int w, n;
        bit stable;
        logic [N-1:0] e;
        w = ref_pick(req_i, ref_ptr);
        if (w < 0) w = 0;
        e = '0;
        e[w] = 1'b1;
        n = 0;
        while (gnt_o === '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        won = onehot_idx(gnt_o);
        check({tag, ".gnt"}, 32'(gnt_o), 32'(e));
        if (exp_lat >= 0) check({tag, ".latency"}, n, exp_lat);
        check({tag, ".setup_strobes"}, {m_sel_o, m_enable_o}, 2'b10);
        stable = 1'b1;
        if (m_addr_o !== pa[w] || m_wdata_o !== pd[w] || m_write_o !== pw[w]) stable = 1'b0;
        if (drop_winner) req_i[w] = 1'b0;
        @(negedge clk);
        check({tag, ".access_strobes"}, {m_sel_o, m_enable_o}, 2'b11);
        n = 0;
        while (done_o === '0 && n < 60) begin
            if (m_addr_o !== pa[w] || m_wdata_o !== pd[w] || m_write_o !== pw[w] || gnt_o !== e)
                stable = 1'b0;
            @(negedge clk);
            n++;
        end
        if (m_addr_o !== pa[w] || m_wdata_o !== pd[w] || m_write_o !== pw[w] || gnt_o !== e)
            stable = 1'b0;
        check({tag, ".payload_stable"}, stable, 1'b1);
        check({tag, ".done"}, 32'(done_o), 32'(e));
        check({tag, ".err"}, err_o, 1'b0);
        check({tag, ".rdata"}, rdata_o, txn_rdata);
        $display("txn %s winner=%0d write=%0b addr=%02h wdata=%02h rdata=%02h",
                 tag, won, pw[w], pa[w], pd[w], rdata_o);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, 32'(done_o), 32'h0);
        check({tag, ".gnt_released"}, 32'(gnt_o), 32'h0);
        ref_ptr = (w + 1) % N;
    endtask

    initial begin
        int won, n;
        bit quiet;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst.gnt", 32'(gnt_o), 32'h0);
        check("rst.done", 32'(done_o), 32'h0);
        check("rst.rdata", rdata_o, 8'h00);
        check("rst.err", err_o, 1'b0);
        check("rst.m_bus", {m_sel_o, m_enable_o, m_write_o, m_addr_o, m_wdata_o}, 17'h0);
        rst_i = 1'b0;
        @(negedge clk);

        // Master busy at start: no SETUP while ready is low
        master_hold = 1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin pw[k] = 1'b1; pa[k] = 7'(8'h10 + k); pd[k] = 8'(8'h20 + k); end
        pack_payload();
        req_i = 4'b0010;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (gnt_o !== '0 || m_sel_o !== 1'b0) quiet = 1'b0;
        end
        check("busy.no_setup", quiet, 1'b1);
        master_hold = 0;
        txn_rdata = 8'h5A; txn_lat = 2;
        run_one("busy", 2, 0, won);
        req_i = '0;

        // Single write from requester 0
        pw[0] = 1'b1; pa[0] = 7'h50; pd[0] = 8'hA5;
        pack_payload();
        txn_rdata = 8'h11; txn_lat = 3;
        req_i = 4'b0001;
        run_one("write0", 1, 0, won);
        check("write0.winner", won, 0);
        req_i = '0;

        // Single read from requester 2
        pw[2] = 1'b0; pa[2] = 7'h2B;
        pack_payload();
        txn_rdata = 8'h3C; txn_lat = 1;
        req_i = 4'b0100;
        run_one("read2", 1, 0, won);
        check("read2.rdata", rdata_o, 8'h3C);
        req_i = '0;

        // Reset during WAIT: outputs clear, no done pulse, pointer back to 0
        req_i = 4'b0100;
        txn_lat = 10;
        n = 0;
        while (gnt_o === '0 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!(gnt_o !== '0 && m_sel_o === 1'b0) && n < 20) begin @(negedge clk); n++; end
        check("rstmid.in_wait", {m_sel_o, m_enable_o, 32'(gnt_o)}, {2'b00, 32'h4});
        rst_i = 1'b1;
        @(negedge clk);
        check("rstmid.gnt", 32'(gnt_o), 32'h0);
        check("rstmid.done", 32'(done_o), 32'h0);
        check("rstmid.bus", {m_sel_o, m_enable_o, m_write_o, m_addr_o, m_wdata_o, rdata_o, err_o}, 26'h0);
        rst_i = 1'b0;
        req_i = '0;
        ref_ptr = 0;
        @(negedge clk);
        check("rstmid.no_done", 32'(done_o), 32'h0);

        // Fairness with all lines held: order 0,1,2,3,0
        rand_payload();
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            txn_lat = $urandom_range(0, 4);
            txn_rdata = 8'($urandom_range(0, 255));
            run_one($sformatf("fair%0d", i), 1, 0, won);
            check($sformatf("fair%0d.order", i), won, i % N);
        end
        req_i = '0;

        // Randomized traffic, including winners dropping their request mid-flight
        for (int i = 0; i < 25; i++) begin
            rand_payload();
            txn_lat = $urandom_range(0, 4);
            txn_rdata = 8'($urandom_range(0, 255));
            req_i = 4'($urandom_range(1, 15));
            run_one($sformatf("rnd%0d", i), 1, 1'($urandom_range(0, 1)), won);
        end
        req_i = '0;

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never returns ready: watchdog completes with err after 16 cycles
        begin
            int w;
            logic [N-1:0] e;
            @(negedge clk);
            req_i = 4'b1111;
            w = ref_pick(req_i, ref_ptr);
            e = '0; e[w] = 1'b1;
            txn_lat = 5000;
            n = 0;
            while (gnt_o === '0 && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
            check("tmo.access", {m_sel_o, m_enable_o}, 2'b11);
            n = 0;
            while (done_o === '0 && n < 40) begin @(negedge clk); n++; end
            check("tmo.cycles", n, 16);
            check("tmo.done", 32'(done_o), 32'(e));
            check("tmo.err", err_o, 1'b1);
            check("tmo.rdata", rdata_o, 8'h00);
            check("tmo.strobes", {m_sel_o, m_enable_o}, 2'b00);
            $display("txn tmo winner=%0d err=%0b", w, err_o);
            ref_ptr = (w + 1) % N;
            master_flush = 1;
            @(negedge clk);
            master_flush = 0;
            txn_lat = 1;
            txn_rdata = 8'h77;
            run_one("tmo.next", -1, 0, won);
            check("tmo.next_winner", won, (w + 1) % N);
            req_i = '0;
        end
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Shares one I2C_master peripheral among NUM_REQ requesters. Each request is granted round-robin and sequenced through the master's setup/enable handshake. Completion is detected from the master's ready flag, and read data is returned to the winner with a one-cycle done pulse. The block sits between the bus-side peripheral clients and the I2C_master instance, and is the only driver of its sel/enable/write/addr/wdata inputs.

## Interface
- NUM_REQ, 4, number of requesters (≥2); index width IW = $clog2(NUM_REQ)
- TIMEOUT_CYCLES, 1024, watchdog limit in clk_i cycles (used only with I2C_ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  single clock, also drives the I2C_master
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  NUM_REQ  per-requester request; held with payload until done_o
- write_i  in  NUM_REQ  per-requester direction (1 = write)
- addr_i  in  7*NUM_REQ  per-requester 7-bit slave address, requester k at [7k+6:7k]
- wdata_i  in  8*NUM_REQ  per-requester write byte, requester k at [8k+7:8k]
- gnt_o  out  NUM_REQ  one-hot grant, held for the whole transaction
- done_o  out  NUM_REQ  one-hot, one-cycle completion pulse
- rdata_o  out  8  read byte of the last completed transaction
- err_o  out  1  valid with done_o: transaction aborted by the watchdog
- m_sel_o, m_enable_o, m_write_o  out  1 each  to master sel_i/enable_i/write_i
- m_addr_o  out  7  to master addr_i
- m_wdata_o  out  8  to master wdata_i
- m_rdata_i  in  8  from master rdata_o
- m_ready_i  in  1  from master ready_o (1 = master idle)

## Operation
- States:
  - IDLE: all master strobes are 0. If m_ready_i=1 and any req_i is set, the arbiter picks a winner, latches its write/addr/wdata and index into registers, and goes to SETUP.
  - SETUP: one cycle with m_sel_o=1, m_enable_o=0. Goes to ACCESS.
  - ACCESS: m_sel_o=1, m_enable_o=1 until m_ready_i=0 is sampled, then WAIT.
  - WAIT: strobes are 0. When m_ready_i=1 is sampled, goes to DONE.
  - DONE: one cycle. done_o[winner]=1, rdata_o is loaded from m_rdata_i (written for writes too), err_o=0. The round-robin pointer becomes winner+1 mod NUM_REQ. Goes to IDLE.
- Arbitration: search starts at the pointer and increments with wrap-around; the first set req_i wins. Pointer resets to 0.
- gnt_o[winner]=1 from SETUP through DONE inclusive, otherwise 0.
- m_write_o, m_addr_o and m_wdata_o are driven from the latched registers and stay stable from SETUP to DONE.
- If the winner drops req_i mid-transaction, it is ignored: the transaction finishes and done_o still pulses.
- New or changed req_i on other lines has no effect until the next IDLE.
- The block accepts no new request while m_ready_i=0 in IDLE, for example while the master is still in reset.

## Timing
- Reset values: gnt_o=0, done_o=0, rdata_o=0, err_o=0, all m_* outputs 0, state IDLE, pointer 0.
- Reset asserted in any state returns to IDLE on the next edge. No done_o pulse is produced for the aborted transaction.
- Request-to-SETUP latency: 1 cycle after req_i is sampled in IDLE.
- Arbitration back-to-back: the earliest next SETUP is 2 cycles after DONE (DONE → IDLE → SETUP).
- All outputs are registered; there are no combinational paths from req_i to m_* outputs.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and counts every cycle in ACCESS and WAIT.
  - Reaching TIMEOUT_CYCLES-1 forces DONE with err_o=1, rdata_o=0 and strobes 0, and the pointer advances normally.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter is built, err_o is tied to 0, and TIMEOUT_CYCLES is ignored. The block waits on m_ready_i indefinitely.

## Structure
- Package i2c_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, WAIT, DONE)
  - I2C_ADDR_W=7 and I2C_DATA_W=8
- One sub-module, rr_pick:
  - inputs: a NUM_REQ request vector and the IW-bit pointer
  - outputs: the one-hot winner and its index, purely combinational
  - instantiated once, with the result registered in IDLE

## Test plan
- Single write: req_i=0001, addr=7'h50, wdata=8'hA5, write=1. Expect:
  - m_sel_o/m_enable_o show the 1/0 then 1/1 sequence
  - m_addr_o=50 and m_wdata_o=A5 stay stable through the whole transaction
  - after m_ready_i rises, done_o=0001 for one cycle with err_o=0
- Single read: requester 2, write=0, and the master model returns 8'h3C. Expect done_o=0100 and rdata_o=3C.
- Fairness: req_i=1111 held continuously. Expect grants in order 0, 1, 2, 3, 0, each granted exactly once per four transactions.
- Timeout (macro defined, TIMEOUT_CYCLES=16): m_ready_i stuck at 0 after SETUP. Expect done_o pulse with err_o=1 and rdata_o=0 16 cycles after ACCESS entry, then the next requester is served.
- Reset mid-transaction: assert rst_i during WAIT. Expect all outputs 0 next cycle, no done_o pulse, and the pointer back to 0 so requester 0 wins next.
- Master busy at start: m_ready_i=0 in IDLE with req_i set. Expect no SETUP until m_ready_i=1.
